// File: rtl/betting_round_ctrl_pkg.sv
// Shared poker types: stack width, default stack, betting actions and round states.
package betting_round_ctrl_pkg;

  // Sized so that a full table of default stacks fits without wrapping.
  localparam int unsigned MAX_STACK_W   = 16;
  localparam int unsigned DEFAULT_STACK = 1000;

  typedef enum logic [1:0] {
    ActFold      = 2'd0,
    ActCheckCall = 2'd1,
    ActRaise     = 2'd2
  } action_t;

  typedef enum logic [2:0] {
    StIdle,
    StPrompt,
    StCommit,
    StCapture,
    StAdvance,
    StDone,
    StPayout
  } bet_state_t;

  // Chip addition clamped at the largest representable amount.
  function automatic logic [MAX_STACK_W-1:0] sat_add(input logic [MAX_STACK_W-1:0] a,
                                                     input logic [MAX_STACK_W-1:0] b);
    logic [MAX_STACK_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[MAX_STACK_W] ? {MAX_STACK_W{1'b1}} : s[MAX_STACK_W-1:0];
  endfunction

endpackage

// File: rtl/betting_round_ctrl_seat_scan.sv
// Wrap-around finder: first seat at or after start_idx whose mask bit is set.
module betting_round_ctrl_seat_scan #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned SEAT_W      = $clog2(NUM_PLAYERS)
) (
  input  logic [SEAT_W-1:0]      start_idx,
  input  logic [NUM_PLAYERS-1:0] mask,
  output logic [SEAT_W-1:0]      idx,
  output logic                   found
);

  int unsigned       j;
  logic [SEAT_W-1:0] cand;

  // Priority scan in seating order starting from start_idx.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      j    = (32'(start_idx) + i) % NUM_PLAYERS;
      cand = SEAT_W'(j);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/betting_round_ctrl.sv
// Betting round sequencer: prompts seats, commits bets to players, tracks pot, pays winner.
module betting_round_ctrl
  import betting_round_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned SEAT_W      = $clog2(NUM_PLAYERS)
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       start_round,
  input  logic [SEAT_W-1:0]                          dealer_idx,
  input  logic                                       action_valid,
  output logic                                       action_ready,
  input  logic [1:0]                                 action_type,
  input  logic [MAX_STACK_W-1:0]                     raise_amount,
  input  logic [NUM_PLAYERS-1:0][MAX_STACK_W-1:0]    seat_prev_bet,
  input  logic [NUM_PLAYERS-1:0][MAX_STACK_W-1:0]    seat_stack,
  output logic [NUM_PLAYERS-1:0]                     seat_en,
  output logic                                       seat_make_bet,
  output logic                                       seat_add_profit,
  output logic [MAX_STACK_W-1:0]                     seat_bet_amount,
  output logic [SEAT_W-1:0]                          acting_seat,
  output logic [MAX_STACK_W-1:0]                     current_bet,
  output logic [MAX_STACK_W-1:0]                     pot,
  output logic [NUM_PLAYERS-1:0]                     folded,
  output logic                                       round_done,
  output logic                                       one_left,
  input  logic                                       winner_valid,
  input  logic [SEAT_W-1:0]                          winner_idx
);

  bet_state_t                              state_q, state_d;
  logic [SEAT_W-1:0]                       acting_q, acting_d;
  logic [MAX_STACK_W-1:0]                  current_bet_q, current_bet_d;
  logic [MAX_STACK_W-1:0]                  pot_q, pot_d;
  logic [NUM_PLAYERS-1:0]                  folded_q, folded_d;
  logic [NUM_PLAYERS-1:0]                  acted_q, acted_d;
  logic [NUM_PLAYERS-1:0]                  allin_q, allin_d;
  logic [NUM_PLAYERS-1:0][MAX_STACK_W-1:0] contrib_q, contrib_d;
  logic                                    one_left_q, one_left_d;
  // Player strobes are registered so they cannot glitch while the state decodes.
  logic [NUM_PLAYERS-1:0]                  seat_en_q, seat_en_d;
  logic                                    make_bet_q, make_bet_d;
  logic                                    add_profit_q, add_profit_d;
  logic [MAX_STACK_W-1:0]                  bet_amount_q, bet_amount_d;

  logic [NUM_PLAYERS-1:0]  stack_nz, eligible;
  logic [SEAT_W-1:0]       first_seat, after_acting, scan_start, scan_idx;
  logic [NUM_PLAYERS-1:0]  scan_mask;
  logic                    scan_found, all_matched;
  logic [MAX_STACK_W-1:0]  cur_contrib, to_call, cap_bet, new_contrib;

  function automatic logic [NUM_PLAYERS-1:0] seat_onehot(input logic [SEAT_W-1:0] s);
    return NUM_PLAYERS'(1) << s;
  endfunction

  assign eligible     = ~folded_q & ~allin_q;
  assign first_seat   = SEAT_W'((32'(dealer_idx) + 32'd1) % NUM_PLAYERS);
  assign after_acting = SEAT_W'((32'(acting_q) + 32'd1) % NUM_PLAYERS);
  // IDLE scans the fresh stacks; ADVANCE scans the live eligibility mask.
  assign scan_start   = (state_q == StIdle) ? first_seat : after_acting;
  assign scan_mask    = (state_q == StIdle) ? stack_nz : eligible;
  assign cur_contrib  = contrib_q[acting_q];
  assign to_call      = current_bet_q - cur_contrib;
  assign cap_bet      = seat_prev_bet[acting_q];
  assign new_contrib  = sat_add(cur_contrib, cap_bet);

  betting_round_ctrl_seat_scan #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .SEAT_W      (SEAT_W)
  ) u_seat_scan (
    .start_idx (scan_start),
    .mask      (scan_mask),
    .idx       (scan_idx),
    .found     (scan_found)
  );

  // Per-seat flags: non-empty stack and "acted and matched" for round closure.
  always_comb begin
    stack_nz    = '0;
    all_matched = 1'b1;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      stack_nz[p] = (seat_stack[p] != '0);
      if (eligible[p] && !(acted_q[p] && (contrib_q[p] == current_bet_q))) begin
        all_matched = 1'b0;
      end
    end
  end

  // Round FSM next-state, datapath updates and next player strobes.
  always_comb begin
    state_d       = state_q;
    acting_d      = acting_q;
    current_bet_d = current_bet_q;
    pot_d         = pot_q;
    folded_d      = folded_q;
    acted_d       = acted_q;
    allin_d       = allin_q;
    contrib_d     = contrib_q;
    one_left_d    = one_left_q;
    seat_en_d     = '0;
    make_bet_d    = 1'b0;
    add_profit_d  = 1'b0;
    bet_amount_d  = '0;
    case (state_q)
      StIdle: begin
        if (start_round) begin
          contrib_d     = '0;
          folded_d      = '0;
          acted_d       = '0;
          pot_d         = '0;
          current_bet_d = '0;
          one_left_d    = 1'b0;
          allin_d       = ~stack_nz;
          acting_d      = scan_idx;
          state_d       = ($countones(stack_nz) < 2) ? StDone : StPrompt;
        end
      end
      StPrompt: begin
        if (action_valid) begin
          case (action_type)
            ActCheckCall: begin
              if (to_call == '0) begin
                acted_d[acting_q] = 1'b1;
                state_d           = StAdvance;
              end else begin
                seat_en_d    = seat_onehot(acting_q);
                make_bet_d   = 1'b1;
                bet_amount_d = to_call;
                state_d      = StCommit;
              end
            end
            ActRaise: begin
              seat_en_d    = seat_onehot(acting_q);
              make_bet_d   = 1'b1;
              bet_amount_d = sat_add(to_call, raise_amount);
              state_d      = StCommit;
            end
            default: begin
              folded_d[acting_q] = 1'b1;
              state_d            = StAdvance;
            end
          endcase
        end
      end
      StCommit: state_d = StCapture;
      StCapture: begin
        // prev_bet already holds the amount the player could actually cover.
        contrib_d[acting_q] = new_contrib;
        pot_d               = sat_add(pot_q, cap_bet);
        acted_d[acting_q]   = 1'b1;
        if (seat_stack[acting_q] == '0) allin_d[acting_q] = 1'b1;
        if (new_contrib > current_bet_q) begin
          current_bet_d = new_contrib;
          acted_d       = seat_onehot(acting_q);
        end
        state_d = StAdvance;
      end
      StAdvance: begin
        if ($countones(~folded_q) == 1) begin
          one_left_d = 1'b1;
          state_d    = StDone;
        end else if (all_matched || !scan_found) begin
          state_d = StDone;
        end else begin
          acting_d = scan_idx;
          state_d  = StPrompt;
        end
      end
      StDone: begin
        if (winner_valid) begin
          if (pot_q != '0) begin
            seat_en_d    = seat_onehot(winner_idx);
            add_profit_d = 1'b1;
            bet_amount_d = pot_q;
            state_d      = StPayout;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StPayout: begin
        pot_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any round in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      acting_q      <= '0;
      current_bet_q <= '0;
      pot_q         <= '0;
      folded_q      <= '0;
      acted_q       <= '0;
      allin_q       <= '0;
      contrib_q     <= '0;
      one_left_q    <= 1'b0;
      seat_en_q     <= '0;
      make_bet_q    <= 1'b0;
      add_profit_q  <= 1'b0;
      bet_amount_q  <= '0;
    end else begin
      state_q       <= state_d;
      acting_q      <= acting_d;
      current_bet_q <= current_bet_d;
      pot_q         <= pot_d;
      folded_q      <= folded_d;
      acted_q       <= acted_d;
      allin_q       <= allin_d;
      contrib_q     <= contrib_d;
      one_left_q    <= one_left_d;
      seat_en_q     <= seat_en_d;
      make_bet_q    <= make_bet_d;
      add_profit_q  <= add_profit_d;
      bet_amount_q  <= bet_amount_d;
    end
  end

  assign action_ready    = (state_q == StPrompt);
  assign round_done      = (state_q == StDone);
  assign seat_en         = seat_en_q;
  assign seat_make_bet   = make_bet_q;
  assign seat_add_profit = add_profit_q;
  assign seat_bet_amount = bet_amount_q;
  assign acting_seat     = acting_q;
  assign current_bet     = current_bet_q;
  assign pot             = pot_q;
  assign folded          = folded_q;
  assign one_left        = one_left_q;

endmodule

// File: tb/tb_betting_round_ctrl.sv
// Bench for betting_round_ctrl with four behavioural players and a strobe scoreboard.
module tb_betting_round_ctrl;
  import betting_round_ctrl_pkg::*;

  localparam int NP = 4;
  localparam int SW = 2;
  localparam int W  = MAX_STACK_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              plr_rst_n = 1'b0;
  logic              start_round = 1'b0;
  logic [SW-1:0]     dealer_idx = '0;
  logic              action_valid = 1'b0;
  logic              action_ready;
  logic [1:0]        action_type = '0;
  logic [W-1:0]      raise_amount = '0;
  logic [NP-1:0][W-1:0] p_prev, p_stack;
  logic [NP-1:0]     seat_en;
  logic              seat_make_bet, seat_add_profit;
  logic [W-1:0]      seat_bet_amount, current_bet, pot;
  logic [SW-1:0]     acting_seat, winner_idx = '0;
  logic [NP-1:0]     folded;
  logic              round_done, one_left;
  logic              winner_valid = 1'b0;

  logic [NP-1:0][W-1:0] init_stack;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  betting_round_ctrl #(.NUM_PLAYERS(NP), .SEAT_W(SW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start_round     (start_round),
    .dealer_idx      (dealer_idx),
    .action_valid    (action_valid),
    .action_ready    (action_ready),
    .action_type     (action_type),
    .raise_amount    (raise_amount),
    .seat_prev_bet   (p_prev),
    .seat_stack      (p_stack),
    .seat_en         (seat_en),
    .seat_make_bet   (seat_make_bet),
    .seat_add_profit (seat_add_profit),
    .seat_bet_amount (seat_bet_amount),
    .acting_seat     (acting_seat),
    .current_bet     (current_bet),
    .pot             (pot),
    .folded          (folded),
    .round_done      (round_done),
    .one_left        (one_left),
    .winner_valid    (winner_valid),
    .winner_idx      (winner_idx)
  );

  // Behavioural players: a bet is clipped to the stack; profit adds to it.
  always @(posedge clk or negedge plr_rst_n) begin
    if (!plr_rst_n) begin
      p_stack <= init_stack;
      p_prev  <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (seat_en[p] && seat_make_bet) begin
          p_stack[p] <= p_stack[p] - ((seat_bet_amount > p_stack[p]) ? p_stack[p] : seat_bet_amount);
          p_prev[p]  <= (seat_bet_amount > p_stack[p]) ? p_stack[p] : seat_bet_amount;
        end else if (seat_en[p] && seat_add_profit) begin
          p_stack[p] <= p_stack[p] + seat_bet_amount;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Strobe scoreboard: expected player commands queued when the action is driven.
  typedef struct {
    logic [NP-1:0] en;
    logic          mb;
    logic          ap;
    logic [W-1:0]  amt;
  } strobe_t;
  strobe_t exp_q[$];
  strobe_t mon_e;

  always @(negedge clk) begin
    if (seat_make_bet || seat_add_profit) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, seat_make_bet, seat_add_profit}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_seat_en", 32'(seat_en), 32'(mon_e.en));
        check("strobe_make_bet", 32'(seat_make_bet), 32'(mon_e.mb));
        check("strobe_add_profit", 32'(seat_add_profit), 32'(mon_e.ap));
        check("strobe_bet_amount", 32'(seat_bet_amount), 32'(mon_e.amt));
      end
    end else if (seat_en != '0) begin
      check("seat_en_without_strobe", 32'(seat_en), 32'd0);
    end
  end

  typedef struct {
    int seat;
    int act;
    int raise;
    bit bet;
    int amt;
  } vec_t;
  vec_t vt[21];

  task automatic do_reset();
    start_round  = 1'b0;
    action_valid = 1'b0;
    winner_valid = 1'b0;
    reset_n      = 1'b0;
    plr_rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    plr_rst_n = 1'b1;
  endtask

  task automatic start(input int dealer);
    @(negedge clk);
    dealer_idx  = SW'(dealer);
    start_round = 1'b1;
    @(posedge clk);
    #1 start_round = 1'b0;
  endtask

  task automatic do_action(input int seat, input int act, input int raise, input bit bet,
                           input int amt, input bit push);
    int n;
    logic [NP-1:0] en;
    strobe_t e;
    n = 0;
    @(negedge clk);
    while (!action_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("action_ready", 32'(action_ready), 32'd1);
    if (!action_ready) return;
    check("prompt_seat", 32'(acting_seat), 32'(seat));
    en = 4'b0001 << seat;
    if (bet && push) begin
      e.en = en; e.mb = 1'b1; e.ap = 1'b0; e.amt = W'(amt);
      exp_q.push_back(e);
    end
    action_valid = 1'b1;
    action_type  = 2'(act);
    raise_amount = W'(raise);
    @(posedge clk);
    #1 action_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    do_action(vt[i].seat, vt[i].act, vt[i].raise, vt[i].bet, vt[i].amt, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!round_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("round_done", 32'(round_done), 32'd1);
  endtask

  task automatic pay(input int winner, input int amt, input bit strobe);
    strobe_t e;
    @(negedge clk);
    winner_valid = 1'b1;
    winner_idx   = SW'(winner);
    if (strobe) begin
      e.en = 4'b0001 << winner; e.mb = 1'b0; e.ap = 1'b1; e.amt = W'(amt);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 winner_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_seat_en"}, 32'(seat_en), 32'd0);
    check({tag, "_make_bet"}, 32'(seat_make_bet), 32'd0);
    check({tag, "_add_profit"}, 32'(seat_add_profit), 32'd0);
    check({tag, "_bet_amount"}, 32'(seat_bet_amount), 32'd0);
    check({tag, "_pot"}, 32'(pot), 32'd0);
    check({tag, "_current_bet"}, 32'(current_bet), 32'd0);
    check({tag, "_folded"}, 32'(folded), 32'd0);
    check({tag, "_acting_seat"}, 32'(acting_seat), 32'd0);
    check({tag, "_round_done"}, 32'(round_done), 32'd0);
    check({tag, "_one_left"}, 32'(one_left), 32'd0);
    check({tag, "_action_ready"}, 32'(action_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // seat, action(0 fold,1 check/call,2 raise), raise, expects make_bet, bet_amount
    vt[0]  = '{1, 1, 0, 1'b0, 0};    // all check
    vt[1]  = '{2, 1, 0, 1'b0, 0};
    vt[2]  = '{3, 1, 0, 1'b0, 0};
    vt[3]  = '{0, 1, 0, 1'b0, 0};
    vt[4]  = '{1, 2, 50, 1'b1, 50};  // raise then calls
    vt[5]  = '{2, 1, 0, 1'b1, 50};
    vt[6]  = '{3, 1, 0, 1'b1, 50};
    vt[7]  = '{0, 1, 0, 1'b1, 50};
    vt[8]  = '{1, 2, 50, 1'b1, 50};  // re-raise reopens action
    vt[9]  = '{2, 2, 100, 1'b1, 150};
    vt[10] = '{3, 0, 0, 1'b0, 0};
    vt[11] = '{0, 1, 0, 1'b1, 150};
    vt[12] = '{1, 1, 0, 1'b1, 100};
    vt[13] = '{1, 2, 20, 1'b1, 20};  // fold-out
    vt[14] = '{2, 0, 0, 1'b0, 0};
    vt[15] = '{3, 3, 0, 1'b0, 0};    // reserved code folds
    vt[16] = '{0, 0, 0, 1'b0, 0};
    vt[17] = '{1, 2, 100, 1'b1, 100}; // short all-in
    vt[18] = '{2, 1, 0, 1'b1, 100};
    vt[19] = '{3, 1, 0, 1'b1, 100};
    vt[20] = '{0, 1, 0, 1'b1, 100};

    for (int p = 0; p < NP; p++) init_stack[p] = W'(DEFAULT_STACK);

    // Reset state, observed asynchronously before any clock edge.
    #3 check_all_zero("reset");
    do_reset();

    // All check: no bets, 1-cycle advance between prompts.
    start(0);
    run_vec(0);
    @(negedge clk);
    check("s1_advance_ready", 32'(action_ready), 32'd0);
    @(negedge clk);
    check("s1_next_prompt_ready", 32'(action_ready), 32'd1);
    check("s1_next_prompt_seat", 32'(acting_seat), 32'd2);
    for (int i = 1; i < 4; i++) run_vec(i);
    wait_done();
    check("s1_pot", 32'(pot), 32'd0);
    check("s1_current_bet", 32'(current_bet), 32'd0);
    check("s1_one_left", 32'(one_left), 32'd0);
    pay(0, 0, 1'b0);
    @(negedge clk);
    check("s1_idle_after_empty_pot", 32'(round_done), 32'd0);

    // Raise then calls, two-cycle pot latency, payout to seat 3.
    do_reset();
    start(0);
    run_vec(4);
    @(negedge clk);
    check("s2_pot_commit", 32'(pot), 32'd0);
    @(negedge clk);
    check("s2_pot_capture", 32'(pot), 32'd0);
    @(negedge clk);
    check("s2_pot_after_2", 32'(pot), 32'd50);
    check("s2_cb_after_raise", 32'(current_bet), 32'd50);
    for (int i = 5; i < 8; i++) run_vec(i);
    wait_done();
    check("s2_pot", 32'(pot), 32'd200);
    check("s2_current_bet", 32'(current_bet), 32'd50);
    pay(3, 200, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("s2_pot_cleared", 32'(pot), 32'd0);
    check("s2_idle", 32'(round_done), 32'd0);
    check("s2_p3_stack", 32'(p_stack[3]), 32'd1150);

    // Re-raise reopens action for seat 1.
    do_reset();
    start(0);
    for (int i = 8; i < 13; i++) run_vec(i);
    wait_done();
    check("s3_pot", 32'(pot), 32'd450);
    check("s3_current_bet", 32'(current_bet), 32'd150);
    check("s3_folded", 32'(folded), 32'b1000);
    check("s3_one_left", 32'(one_left), 32'd0);

    // Fold-out; start_round ignored in DONE; payout to survivor.
    do_reset();
    start(0);
    for (int i = 13; i < 17; i++) run_vec(i);
    @(negedge clk);
    check("s4_advance_not_done", 32'(round_done), 32'd0);
    @(negedge clk);
    check("s4_done", 32'(round_done), 32'd1);
    check("s4_one_left", 32'(one_left), 32'd1);
    check("s4_pot", 32'(pot), 32'd20);
    check("s4_folded", 32'(folded), 32'b1101);
    @(negedge clk);
    start_round = 1'b1;
    @(posedge clk);
    #1 start_round = 1'b0;
    @(negedge clk);
    check("s4_start_ignored_done", 32'(round_done), 32'd1);
    check("s4_start_ignored_pot", 32'(pot), 32'd20);
    pay(1, 20, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("s4_p1_stack", 32'(p_stack[1]), 32'd1000);
    check("s4_pot_cleared", 32'(pot), 32'd0);

    // Short all-in: seat 2 covers only 30 and is skipped afterwards.
    init_stack[2] = W'(30);
    do_reset();
    start(0);
    run_vec(17);
    run_vec(18);
    repeat (3) @(negedge clk);
    check("s5_pot_after_allin", 32'(pot), 32'd130);
    check("s5_cb_not_lowered", 32'(current_bet), 32'd100);
    check("s5_p2_stack", 32'(p_stack[2]), 32'd0);
    run_vec(19);
    run_vec(20);
    wait_done();
    check("s5_pot", 32'(pot), 32'd330);
    check("s5_current_bet", 32'(current_bet), 32'd100);
    init_stack[2] = W'(DEFAULT_STACK);

    // Reset during COMMIT: strobes drop asynchronously, player untouched.
    do_reset();
    start(0);
    do_action(1, 1, 0, 1'b0, 0, 1'b0);
    do_action(2, 1, 0, 1'b0, 0, 1'b0);
    do_action(3, 1, 0, 1'b0, 0, 1'b0);
    do_action(0, 2, 40, 1'b1, 40, 1'b0);
    check("s6_commit_en", 32'(seat_en), 32'b0001);
    check("s6_commit_make_bet", 32'(seat_make_bet), 32'd1);
    check("s6_commit_amount", 32'(seat_bet_amount), 32'd40);
    #1 reset_n = 1'b0;
    #1 check_all_zero("s6_async");
    @(posedge clk);
    #1 check("s6_p0_stack", 32'(p_stack[0]), 32'd1000);
    reset_n = 1'b1;
    @(negedge clk);
    check("s6_idle_ready", 32'(action_ready), 32'd0);

    // Fewer than two funded seats: straight to DONE, nothing to pay.
    for (int p = 1; p < NP; p++) init_stack[p] = '0;
    do_reset();
    start(0);
    @(negedge clk);
    check("s7_direct_done", 32'(round_done), 32'd1);
    check("s7_no_prompt", 32'(action_ready), 32'd0);
    pay(0, 0, 1'b0);
    @(negedge clk);
    check("s7_idle", 32'(round_done), 32'd0);

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/betting_round_ctrl.md
Name: betting_round_ctrl

Overview:
- Table-level controller that drives the per-seat player command interface: `en`, `make_bet`, `add_profit`, `bet_amount`, and reads back `prev_bet` and `current_stack`.
- Sequences one betting round: prompts the acting seat, commits its bet, captures the actual (all-in-clipped) amount into the pot, and advances around the table until bets are matched.
- Then pays the pot to the winner supplied by the showdown logic.
- Sits between the game FSM/UI action source and the array of player instances.

Parameters:
- `NUM_PLAYERS`, 4, number of seats (2..8).
- `SEAT_W`, `$clog2(NUM_PLAYERS)`, seat index width.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_round`  in  1  pulse; accepted only in IDLE.
- `dealer_idx`  in  SEAT_W  dealer seat; first actor is (dealer_idx+1) mod NUM_PLAYERS.
- `action_valid`  in  1  action offered by the acting seat.
- `action_ready`  out  1  high only in PROMPT.
- `action_type`  in  2  0=FOLD, 1=CHECK_CALL, 2=RAISE, 3=reserved (treated as FOLD).
- `raise_amount`  in  MAX_STACK_W  chips above the call amount.
- `seat_prev_bet`  in  NUM_PLAYERS x MAX_STACK_W  player `prev_bet` outputs.
- `seat_stack`  in  NUM_PLAYERS x MAX_STACK_W  player `current_stack` outputs.
- `seat_en`  out  NUM_PLAYERS  one-hot enable to the addressed player.
- `seat_make_bet`  out  1  shared `make_bet`.
- `seat_add_profit`  out  1  shared `add_profit`.
- `seat_bet_amount`  out  MAX_STACK_W  shared `bet_amount`.
- `acting_seat`  out  SEAT_W  seat currently prompted.
- `current_bet`  out  MAX_STACK_W  highest contribution this round.
- `pot`  out  MAX_STACK_W  chips collected.
- `folded`  out  NUM_PLAYERS  fold mask.
- `round_done`  out  1  level, high in DONE.
- `one_left`  out  1  round ended by folds.
- `winner_valid`  in  1  winner presented (sampled in DONE only).
- `winner_idx`  in  SEAT_W  winning seat.

Behaviour:
- **Reset** (async, `reset_n`=0): state IDLE.
  - All outputs 0: `seat_en`, strobes, `seat_bet_amount`, `pot`, `current_bet`, `folded`, `acting_seat`, `round_done`, `one_left`.
  - Internal `contrib[]`, `acted`, `allin` masks are 0.
  - Reset mid-round abandons the round; the pot is lost; no strobe may glitch out.
- **Per-seat state**:
  - `contrib[p]` is MAX_STACK_W wide.
  - `acted` and `allin` masks.
  - `eligible(p)` = !folded[p] && !allin[p].
- **IDLE**: on `start_round`:
  - clear `contrib`, `folded`, `acted`, `pot`, `current_bet`, `one_left`;
  - set `allin[p]` = (seat_stack[p]==0);
  - `acting_seat` = first eligible seat scanning from dealer_idx+1 with wrap;
  - go to PROMPT.
  - If fewer than 2 eligible seats, go straight to DONE.
- **PROMPT**: `action_ready`=1. On `action_valid`, with to_call = current_bet - contrib[acting]:
  - FOLD: set folded, go to ADVANCE.
  - CHECK_CALL with to_call==0: set acted, go to ADVANCE (no `make_bet`).
  - CHECK_CALL with to_call>0: latch amt = to_call, go to COMMIT.
  - RAISE: latch amt = to_call + raise_amount, saturating at 2^MAX_STACK_W-1; go to COMMIT.
- **COMMIT** (1 cycle): `seat_en`[acting]=1, `seat_make_bet`=1, `seat_bet_amount`=amt.
- **CAPTURE** (1 cycle), with b = seat_prev_bet[acting], the clipped actual bet:
  - contrib += b; pot += b (saturating); set acted;
  - if seat_stack[acting]==0, set allin;
  - if new contrib > current_bet: current_bet = contrib, and acted = only the acting seat (action reopened).
  - A short all-in never lowers `current_bet`.
- **ADVANCE** (1 cycle), round ends when either:
  - non-folded count ==1: set `one_left`, go to DONE; or
  - every eligible seat has acted and contrib==current_bet (includes zero eligible): go to DONE.
  - Otherwise `acting_seat` = next eligible seat after acting, with wrap; go to PROMPT.
- **DONE**: `round_done`=1.
  - On `winner_valid` with pot>0: go to PAYOUT.
  - On `winner_valid` with pot==0: go to IDLE.
  - `start_round` is ignored here.
- **PAYOUT** (1 cycle): `seat_en`[winner_idx]=1, `seat_add_profit`=1, `seat_bet_amount`=pot; pot cleared next cycle; go to IDLE.
- **Strobes**: `seat_make_bet` and `seat_add_profit` are never high together. `seat_en` is 0 outside COMMIT/PAYOUT.
- **Latency**:
  - Accepted bet to pot update: 2 cycles.
  - Fold/check to next prompt: 1 cycle.
- **Chip invariant**: NUM_PLAYERS*DEFAULT_STACK < 2^MAX_STACK_W, so pot saturation is defensive only.

Decomposition:
- Add to the shared poker types package:
  - `action_t` enum (FOLD, CHECK_CALL, RAISE);
  - `bet_state_t` enum (IDLE, PROMPT, COMMIT, CAPTURE, ADVANCE, DONE, PAYOUT).
- Reuse MAX_STACK_W and DEFAULT_STACK from the package.
- One sub-module: `seat_scan`, a combinational wrap-around next-eligible-seat finder (start index, mask → index, found). Used in IDLE and ADVANCE.

Test Plan:
All scenarios use 4 real player instances, stacks 1000, dealer_idx=0.
1. All check: four CHECK_CALL at current_bet 0 → prompt order 1,2,3,0; no `seat_make_bet` pulse; `round_done`=1, pot=0.
2. Raise then calls: P1 RAISE 50; P2, P3, P0 CHECK_CALL → each COMMIT drives `seat_bet_amount`=50; pot=200, current_bet=50; `round_done` after P0.
3. Re-raise reopens action: P1 RAISE 50; P2 RAISE 100 → bet_amount 150, current_bet 150; P3 FOLD; P0 CHECK_CALL → 150; P1 reprompted, CHECK_CALL → 100; pot=450, folded=4'b1000, done.
4. Fold-out: P1 RAISE 20; P2, P3, P0 FOLD → DONE right after P0's fold; `one_left`=1, pot=20.
5. Short all-in: preload P2 stack 30; P1 RAISE 100; P2 CHECK_CALL → bet_amount 100, captured 30; pot=130, current_bet stays 100; P2 skipped thereafter.
6. Payout and reset: after scenario 2, `winner_valid` with winner_idx=3 → one cycle `seat_en`=4'b1000, `seat_add_profit`=1, bet_amount=200; P3 stack 1150, pot 0, IDLE. Separately, drop `reset_n` during COMMIT → all outputs 0 asynchronously and P0 stack unchanged.
